tx_uart: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/tx_uart.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM states and
// oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  // Wide enough for a 2-stop-bit period (SB_TICK-1 = 31).
  localparam int S_CNT_W    = 5;

endpackage

// File: rtl/tx_uart.sv
// UART transmitter: start, NB_DATA bits LSB first, optional parity, stop; timed by the shared 16x s_tick.
// Line goes low one clock after tx_start is accepted in IDLE; requests while busy are dropped, not queued.
module tx_uart
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               tx_start,
  input  logic [NB_DATA-1:0] din,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done_tick
);

  localparam int                 N_CNT_W   = $clog2(NB_DATA);
  localparam logic [S_CNT_W-1:0] S_LAST    = S_CNT_W'(OVERSAMPLE - 1);
  localparam logic [S_CNT_W-1:0] STOP_LAST = S_CNT_W'(SB_TICK - 1);
  localparam logic [N_CNT_W-1:0] N_LAST    = N_CNT_W'(NB_DATA - 1);
  localparam logic               PAR_INV   = (PARITY_ODD != 0);

  uart_state_t        state;
  logic [S_CNT_W-1:0] s_cnt;
  logic [N_CNT_W-1:0] n_cnt;
  logic [NB_DATA-1:0] b_reg;
  logic               par_reg;

  assign tx_busy = (state != IDLE);

  // tx is loaded with the level of the state being entered, so it changes
  // on the same edge as the state and never glitches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      par_reg      <= 1'b0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            state   <= START;
            b_reg   <= din;
            s_cnt   <= '0;
            par_reg <= 1'b0;
            tx      <= 1'b0;
          end
        end

        START: begin
          if (s_tick) begin
            if (s_cnt == S_LAST) begin
              state <= DATA;
              s_cnt <= '0;
              n_cnt <= '0;
              tx    <= b_reg[0];
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s_cnt == S_LAST) begin
              s_cnt   <= '0;
              par_reg <= par_reg ^ b_reg[0];
              b_reg   <= b_reg >> 1;
              if (n_cnt == N_LAST) begin
                if (PARITY_EN != 0) begin
                  state <= PARITY;
                  tx    <= par_reg ^ b_reg[0] ^ PAR_INV;
                end else begin
                  state <= STOP;
                  tx    <= 1'b1;
                end
              end else begin
                n_cnt <= n_cnt + 1'b1;
                tx    <= b_reg[1];
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (s_tick) begin
            if (s_cnt == S_LAST) begin
              state <= STOP;
              s_cnt <= '0;
              tx    <= 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (s_tick) begin
            if (s_cnt == STOP_LAST) begin
              state        <= IDLE;
              s_cnt        <= '0;
              tx_done_tick <= 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
